// File: rtl/spi_controller.sv
// spi_controller: CPU-facing SPI master (mode 0, MSB first) with a 2-bit
// device select register and a programmable SCK divider.
//
// Ports
//   CLK1, RESET     system clock, synchronous active-high reset
//   cs              decoder select; qualifies wr_stb / rd_stb
//   addr[1:0]       0 CTRL/STATUS, 1 DATA, 2 DIV, 3 reserved
//   wr_stb, rd_stb  one-cycle bus strobes
//   wdata[7:0]      CPU write data
//   rdata[7:0]      combinational read data selected by addr
//   waiting         stretch request: cs on DATA while a byte is in flight
//   spi_sck/sdo/sdi SPI pins (sck idles low)
//   spi_select[1:0] device select, forwarded straight from the register
module spi_controller #(
  parameter logic [7:0] DIV_RESET = 8'd31
) (
  input  logic       CLK1,
  input  logic       RESET,
  input  logic       cs,
  input  logic [1:0] addr,
  input  logic       wr_stb,
  input  logic       rd_stb,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       waiting,
  output logic       spi_sck,
  output logic       spi_sdo,
  input  logic       spi_sdi,
  output logic [1:0] spi_select
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;

  logic [1:0] state_q,   state_d;
  logic [1:0] select_q,  select_d;
  logic [7:0] div_q,     div_d;
  logic [7:0] divcnt_q,  divcnt_d;
  logic [2:0] bitcnt_q,  bitcnt_d;
  logic [7:0] shift_q,   shift_d;
  logic [7:0] rx_q,      rx_d;
  logic       rxbit_q,   rxbit_d;
  logic       sdo_hold_q, sdo_hold_d;
  logic       overrun_q, overrun_d;

  logic busy;
  logic wr_any;

  assign busy   = (state_q != ST_IDLE);
  assign wr_any = cs && wr_stb;

  always_comb begin
    state_d    = state_q;
    select_d   = select_q;
    div_d      = div_q;
    divcnt_d   = divcnt_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    rx_d       = rx_q;
    rxbit_d    = rxbit_q;
    sdo_hold_d = sdo_hold_q;
    overrun_d  = overrun_q;

    // Set has priority over the STATUS-read clear.
    if (wr_any && busy && (addr != 2'd3)) begin
      overrun_d = 1'b1;
    end else if (cs && rd_stb && (addr == 2'd0)) begin
      overrun_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (wr_any) begin
          case (addr)
            2'd0: select_d = wdata[1:0];
            2'd1: begin
              shift_d  = wdata;
              bitcnt_d = '0;
              divcnt_d = div_q;
              state_d  = ST_LOW;
            end
            2'd2: div_d = wdata;
            default: ;
          endcase
        end
      end
      ST_LOW: begin
        if (divcnt_q == '0) begin
          rxbit_d  = spi_sdi;
          divcnt_d = div_q;
          state_d  = ST_HIGH;
        end else begin
          divcnt_d = divcnt_q - 8'd1;
        end
      end
      ST_HIGH: begin
        if (divcnt_q == '0) begin
          shift_d = {shift_q[6:0], rxbit_q};
          if (bitcnt_q == 3'd7) begin
            rx_d       = {shift_q[6:0], rxbit_q};
            // Keep the last transmitted bit on the pin once the shifter moves on.
            sdo_hold_d = shift_q[7];
            state_d    = ST_IDLE;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
            divcnt_d = div_q;
            state_d  = ST_LOW;
          end
        end else begin
          divcnt_d = divcnt_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK1) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      select_q   <= '0;
      div_q      <= DIV_RESET;
      divcnt_q   <= '0;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      rx_q       <= '0;
      rxbit_q    <= 1'b0;
      sdo_hold_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      select_q   <= select_d;
      div_q      <= div_d;
      divcnt_q   <= divcnt_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      rx_q       <= rx_d;
      rxbit_q    <= rxbit_d;
      sdo_hold_q <= sdo_hold_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    case (addr)
      2'd0:    rdata = {busy, overrun_q, 4'b0000, select_q};
      2'd1:    rdata = rx_q;
      2'd2:    rdata = div_q;
      default: rdata = '0;
    endcase
  end

  assign waiting    = cs && (addr == 2'd1) && busy;
  assign spi_sck    = (state_q == ST_HIGH);
  assign spi_sdo    = (state_q == ST_IDLE) ? sdo_hold_q : shift_q[7];
  assign spi_select = select_q;

endmodule

// File: tb/tb_spi_controller.sv
module tb_spi_controller;

  logic       CLK1 = 1'b0;
  logic       RESET = 1'b1;
  logic       cs = 1'b0;
  logic [1:0] addr = 2'd0;
  logic       wr_stb = 1'b0;
  logic       rd_stb = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       waiting;
  logic       spi_sck;
  logic       spi_sdo;
  logic       spi_sdi = 1'b0;
  logic [1:0] spi_select;

  spi_controller #(.DIV_RESET(8'd31)) dut (
    .CLK1(CLK1), .RESET(RESET), .cs(cs), .addr(addr), .wr_stb(wr_stb),
    .rd_stb(rd_stb), .wdata(wdata), .rdata(rdata), .waiting(waiting),
    .spi_sck(spi_sck), .spi_sdo(spi_sdo), .spi_sdi(spi_sdi),
    .spi_select(spi_select)
  );

  always #5 CLK1 = ~CLK1;

  int n_cmp = 0;
  int n_err = 0;
  bit en = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: a transfer is a start edge, a divider and two bytes;
  // everything visible on the pins follows from the elapsed cycle count.
  int         E = 0;
  bit         m_active = 1'b0;
  int         m_start = 0;
  int         m_hp = 1;
  logic [7:0] m_tx = 8'h00;
  logic [7:0] m_pat = 8'h00;
  logic [7:0] m_rx = 8'h00;
  logic [7:0] m_div = 8'd31;
  logic [1:0] m_select = 2'b00;
  bit         m_ov = 1'b0;
  bit         m_hold = 1'b0;
  bit         m_busy = 1'b0;
  bit         m_sck = 1'b0;
  bit         m_sdo = 1'b0;
  bit         m_sdi = 1'b0;
  logic [7:0] pat = 8'h00;

  always @(posedge CLK1) begin
    int e, half, b;
    bit busy_b;
    E++;
    if (RESET) begin
      m_active = 1'b0; m_select = 2'b00; m_div = 8'd31; m_rx = 8'h00;
      m_ov = 1'b0; m_hold = 1'b0;
    end else begin
      busy_b = m_busy;
      if (cs && rd_stb && addr == 2'd0) m_ov = 1'b0;
      if (cs && wr_stb && busy_b && addr != 2'd3) m_ov = 1'b1;
      if (cs && wr_stb && !busy_b) begin
        case (addr)
          2'd0: m_select = wdata[1:0];
          2'd1: begin
            m_active = 1'b1; m_start = E; m_hp = int'(m_div) + 1;
            m_tx = wdata; m_pat = pat;
          end
          2'd2: m_div = wdata;
          default: ;
        endcase
      end
      if (m_active && (E - m_start) >= 16 * m_hp) begin
        m_active = 1'b0; m_rx = m_pat; m_hold = m_tx[0];
      end
    end
    if (m_active) begin
      e = E - m_start;
      half = e / m_hp;
      b = half / 2;
      m_busy = 1'b1;
      m_sck = (half % 2) == 1;
      m_sdo = m_tx[7-b];
      m_sdi = m_pat[7-b];
    end else begin
      m_busy = 1'b0; m_sck = 1'b0; m_sdo = m_hold; m_sdi = 1'b0;
    end
  end

  always @(negedge CLK1) begin
    logic [7:0] exp_rd;
    if (en) begin
      case (addr)
        2'd0:    exp_rd = {m_busy, m_ov, 4'b0000, m_select};
        2'd1:    exp_rd = m_rx;
        2'd2:    exp_rd = m_div;
        default: exp_rd = 8'h00;
      endcase
      chk("rdata", rdata, exp_rd);
      chk("spi_sck", {7'b0, spi_sck}, {7'b0, m_sck});
      chk("spi_sdo", {7'b0, spi_sdo}, {7'b0, m_sdo});
      chk("spi_select", {6'b0, spi_select}, {6'b0, m_select});
      chk("waiting", {7'b0, waiting}, {7'b0, (cs && addr == 2'd1 && m_busy)});
    end
    spi_sdi = m_sdi;
  end

  logic sdo_q[$];
  always @(posedge spi_sck) begin
    #1 sdo_q.push_back(spi_sdo);
  end

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(posedge CLK1); #2;
    cs = 1'b1; addr = a; wdata = d; wr_stb = 1'b1;
    @(posedge CLK1); #2;
    cs = 1'b0; wr_stb = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    @(posedge CLK1); #2;
    cs = 1'b1; addr = a; rd_stb = 1'b1;
    #1 d = rdata;
    @(posedge CLK1); #2;
    cs = 1'b0; rd_stb = 1'b0;
  endtask

  // Holds cs on DATA and counts stretched cycles until waiting drops.
  task automatic count_waiting(output int cnt);
    cnt = 0;
    cs = 1'b1; addr = 2'd1;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK1);
      if (waiting) cnt++;
      else break;
    end
    #1 cs = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int cnt, runs, len, rises;
    bit prev;
    logic exp_sdo [8];

    repeat (3) @(posedge CLK1);
    #2 en = 1'b1;
    @(posedge CLK1); #2 RESET = 1'b0;

    // Reset values
    rd(2'd0, d); chk("reset STATUS", d, 8'h00);
    rd(2'd2, d); chk("reset DIV", d, 8'h1F);
    rd(2'd1, d); chk("reset DATA", d, 8'h00);
    chk("reset sck", {7'b0, spi_sck}, 8'h00);
    chk("reset select", {6'b0, spi_select}, 8'h00);

    // N=0 transfer, 0xA5 out / 0x3C in
    wr(2'd2, 8'h00);
    wr(2'd0, 8'h01);
    pat = 8'h3C;
    sdo_q.delete();
    wr(2'd1, 8'hA5);
    count_waiting(cnt);
    chk("busy len N=0", cnt[7:0], 8'd16);
    exp_sdo = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    chk("sdo bit count", sdo_q.size() > 255 ? 8'hFF : 8'(sdo_q.size()), 8'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < sdo_q.size()) chk("sdo bit", {7'b0, sdo_q[i]}, {7'b0, exp_sdo[i]});
    end
    rd(2'd1, d); chk("rx 0x3C", d, 8'h3C);
    chk("select 01", {6'b0, spi_select}, 8'h01);
    chk("sdo holds bit0", {7'b0, spi_sdo}, 8'h01);

    // N=3: each SCK phase 4 cycles
    wr(2'd2, 8'h03);
    pat = 8'h5A;
    wr(2'd1, 8'hFF);
    runs = 0; len = 0; prev = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK1);
      if (spi_sck == prev) len++;
      else begin
        chk("sck phase len", len[7:0], 8'd4);
        runs++; prev = spi_sck; len = 1;
      end
      if (runs == 16) break;
    end
    chk("sck phase count", runs[7:0], 8'd16);
    repeat (4) @(posedge CLK1);
    rd(2'd1, d); chk("rx 0x5A", d, 8'h5A);
    pat = 8'h99;
    wr(2'd1, 8'hFF);
    count_waiting(cnt);
    chk("busy len N=3", cnt[7:0], 8'd64);

    // Overrun and waiting qualification during a transfer
    pat = 8'h77;
    wr(2'd1, 8'h12);
    wr(2'd0, 8'h03);
    rd(2'd0, d); chk("STATUS overrun", d, 8'hC1);
    chk("select unchanged", {6'b0, spi_select}, 8'h01);
    @(posedge CLK1); #2 cs = 1'b1; addr = 2'd0;
    @(negedge CLK1); chk("waiting addr0", {7'b0, waiting}, 8'h00);
    #1 addr = 2'd1;
    #1 chk("waiting addr1", {7'b0, waiting}, 8'h01);
    count_waiting(cnt);
    chk("waiting drops", {7'b0, waiting}, 8'h00);
    rd(2'd0, d); chk("STATUS after", d, 8'h01);
    rd(2'd1, d); chk("rx 0x77", d, 8'h77);

    // Reset at the 5th SCK rise, then a fresh transfer
    wr(2'd2, 8'h01);
    pat = 8'hE7;
    wr(2'd1, 8'hC3);
    rises = 0; prev = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK1);
      if (spi_sck && !prev) rises++;
      prev = spi_sck;
      if (rises == 5) break;
    end
    chk("5th rise seen", rises[7:0], 8'd5);
    RESET = 1'b1;
    @(posedge CLK1); #2 RESET = 1'b0;
    chk("post-reset sck", {7'b0, spi_sck}, 8'h00);
    chk("post-reset sdo", {7'b0, spi_sdo}, 8'h00);
    chk("post-reset select", {6'b0, spi_select}, 8'h00);
    rd(2'd0, d); chk("post-reset STATUS", d, 8'h00);
    rd(2'd1, d); chk("post-reset DATA", d, 8'h00);
    rd(2'd2, d); chk("post-reset DIV", d, 8'h1F);
    wr(2'd2, 8'h00);
    wr(2'd0, 8'h01);
    pat = 8'h7E;
    wr(2'd1, 8'h81);
    count_waiting(cnt);
    chk("fresh busy len", cnt[7:0], 8'd16);
    rd(2'd1, d); chk("fresh rx", d, 8'h7E);
    chk("fresh sdo bit0", {7'b0, spi_sdo}, 8'h01);

    repeat (3) @(posedge CLK1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
